// File: rtl/systolic_feeder.sv
// Feeds 8x8 boolean operands into a systolic array as skewed A/B byte pairs, then reads results back.
// Latency: 16 load cycles, 1-2 align, 30 feed, 2*FLUSH_PAIRS flush, READ_CYCLES readout, then 8 result bytes.
// Backpressure: in_ready low outside LOAD; out_data/out_valid hold while out_ready is low in DRAIN.
module systolic_feeder #(
    parameter int FLUSH_PAIRS = 8,
    parameter int READ_CYCLES = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] arr_data,
    output logic       arr_readout,
    input  logic [7:0] arr_result,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam int FEED_CYCLES  = 30;
    localparam int FLUSH_CYCLES = 2 * FLUSH_PAIRS;
    localparam int MAX_A        = (FLUSH_CYCLES > FEED_CYCLES) ? FLUSH_CYCLES : FEED_CYCLES;
    localparam int MAX_CNT      = (READ_CYCLES > MAX_A) ? READ_CYCLES : MAX_A;
    localparam int CNT_W        = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(15);
    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0] RES_FIRST  = CNT_W'(1);
    localparam logic [CNT_W-1:0] RES_LAST   = CNT_W'(8);

    typedef enum logic [2:0] {
        S_LOAD,
        S_ALIGN,
        S_FEED,
        S_FLUSH,
        S_READ,
        S_DRAIN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             phase;
    logic [7:0]       a_mem [8];
    logic [7:0]       b_mem [8];
    logic [7:0]       r_mem [8];

    logic [4:0]       feed_idx;
    logic [3:0]       step;
    logic [7:0]       a_byte;
    logic [7:0]       b_byte;
    logic [7:0]       feed_byte;

    // arr_data is registered, so the skew byte is built for the cycle about to start:
    // even feed index carries the A byte, odd the B byte of step feed_idx/2.
    always_comb begin
        feed_idx = (state == S_ALIGN) ? 5'd0 : (cnt[4:0] + 5'd1);
        step     = feed_idx[4:1];
        a_byte   = '0;
        b_byte   = '0;
        for (int j = 0; j < 8; j++) begin
            for (int m = 0; m < 8; m++) begin
                if (j + m == int'(step)) begin
                    a_byte[j] = a_mem[3'(j)][3'(m)];
                    b_byte[j] = b_mem[3'(m)][3'(j)];
                end
            end
        end
        feed_byte = feed_idx[0] ? b_byte : a_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_LOAD;
            cnt         <= '0;
            phase       <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_data    <= '0;
            arr_readout <= 1'b0;
            arr_data    <= '0;
            busy        <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
                r_mem[i] <= '0;
            end
        end else begin
            phase <= ~phase;
            case (state)
                S_LOAD: begin
                    if (in_valid && in_ready) begin
                        if (cnt[3]) begin
                            b_mem[cnt[2:0]] <= in_data;
                        end else begin
                            a_mem[cnt[2:0]] <= in_data;
                        end
                        if (cnt == LOAD_LAST) begin
                            state    <= S_ALIGN;
                            cnt      <= '0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                S_ALIGN: begin
                    // Leave on a phase=1 cycle so the first feed byte lands on phase=0 (A slot).
                    if (phase) begin
                        state    <= S_FEED;
                        cnt      <= '0;
                        arr_data <= feed_byte;
                    end
                end
                S_FEED: begin
                    if (cnt == FEED_LAST) begin
                        state    <= S_FLUSH;
                        cnt      <= '0;
                        arr_data <= '0;
                    end else begin
                        cnt      <= cnt + CNT_ONE;
                        arr_data <= feed_byte;
                    end
                end
                S_FLUSH: begin
                    if (cnt == FLUSH_LAST) begin
                        state       <= S_READ;
                        cnt         <= '0;
                        arr_readout <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_READ: begin
                    // The array answers one cycle after readout starts: cycles 2..9 carry rows 0..7.
                    if (cnt >= RES_FIRST && cnt <= RES_LAST) begin
                        r_mem[3'(cnt - CNT_ONE)] <= arr_result;
                    end
                    if (cnt == READ_LAST) begin
                        state       <= S_DRAIN;
                        cnt         <= '0;
                        arr_readout <= 1'b0;
                        out_valid   <= 1'b1;
                        out_data    <= r_mem[0];
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (cnt[2:0] == 3'd7) begin
                            state     <= S_LOAD;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            for (int i = 0; i < 8; i++) begin
                                a_mem[i] <= '0;
                                b_mem[i] <= '0;
                            end
                        end else begin
                            cnt      <= cnt + CNT_ONE;
                            out_data <= r_mem[cnt[2:0] + 3'd1];
                        end
                    end
                end
                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: drives operands, models an 8x8 boolean systolic array, scoreboards results.
module tb_systolic_feeder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] arr_data;
    logic       arr_readout;
    logic [7:0] arr_result;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] ma [8];
    logic [7:0] mb [8];
    logic [7:0] stream [30];
    int ro_cycles = 0;

    always #5 clk = ~clk;

    systolic_feeder #(.FLUSH_PAIRS(8), .READ_CYCLES(9)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .arr_data   (arr_data),
        .arr_readout(arr_readout),
        .arr_result (arr_result),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    // Output-stationary array: A shifts right, B shifts down, one step per A/B pair.
    logic       m_phase;
    logic       m_ro_d;
    logic [7:0] m_alat;
    logic [7:0] a_pe [8];
    logic [7:0] b_pe [8];
    logic [7:0] acc [8];
    logic [3:0] ro_idx;

    function automatic logic a_in(input int r, input int c);
        if (c == 0) return m_alat[r];
        return a_pe[r][c-1];
    endfunction

    function automatic logic b_in(input int r, input int c);
        if (r == 0) return arr_data[c];
        return b_pe[r-1][c];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase    <= 1'b0;
            m_ro_d     <= 1'b0;
            m_alat     <= '0;
            ro_idx     <= '0;
            arr_result <= '0;
            for (int r = 0; r < 8; r++) begin
                a_pe[r] <= '0;
                b_pe[r] <= '0;
                acc[r]  <= '0;
            end
        end else begin
            m_phase <= ~m_phase;
            m_ro_d  <= arr_readout;
            if (!m_phase) begin
                m_alat <= arr_data;
            end else begin
                for (int r = 0; r < 8; r++) begin
                    for (int c = 0; c < 8; c++) begin
                        a_pe[r][c] <= a_in(r, c);
                        b_pe[r][c] <= b_in(r, c);
                        if (a_in(r, c) && b_in(r, c)) acc[r][c] <= 1'b1;
                    end
                end
            end
            if (arr_readout) begin
                if (ro_idx < 4'd8) begin
                    arr_result <= acc[ro_idx[2:0]];
                    ro_idx     <= ro_idx + 4'd1;
                end
            end else if (m_ro_d) begin
                ro_idx <= '0;
                for (int r = 0; r < 8; r++) acc[r] <= '0;
            end
        end
    end

    always @(posedge clk) begin
        if (arr_readout === 1'b1) ro_cycles <= ro_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_expected();
        logic [7:0] row;
        for (int r = 0; r < 8; r++) begin
            row = '0;
            for (int c = 0; c < 8; c++)
                for (int k = 0; k < 8; k++)
                    if (ma[r][k] && mb[k][c]) row[c] = 1'b1;
            exp_q.push_back(row);
        end
    endtask

    task automatic load_ops();
        int guard;
        push_expected();
        for (int i = 0; i < 16; i++) begin
            if (i < 8) in_data = ma[i];
            else in_data = mb[i-8];
            in_valid = 1'b1;
            guard = 0;
            while (in_ready !== 1'b1 && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            check("load_in_ready", {31'd0, in_ready}, 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int stall);
        int guard;
        int got;
        logic [7:0] exp;
        guard = 0;
        got = 0;
        out_ready = 1'b0;
        while (out_valid !== 1'b1 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("drain_start_valid", {31'd0, out_valid}, 32'd1);
        for (int s = 0; s < stall; s++) begin
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_data", {24'd0, out_data}, {24'd0, exp_q[0]});
            @(negedge clk);
        end
        out_ready = 1'b1;
        guard = 0;
        while (got < 8 && guard < 100) begin
            if (out_valid === 1'b1) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                check("out_byte", {24'd0, out_data}, {24'd0, exp});
                got++;
            end
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        check("drain_count", got, 8);
        check("busy_after", {31'd0, busy}, 32'd0);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < 8; i++) begin
            ma[i] = 8'($urandom);
            mb[i] = 8'($urandom);
        end
    endtask

    initial begin
        int base;
        int guard;
        int off;
        int hits;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;

        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_readout", {31'd0, arr_readout}, 32'd0);
        check("rst_arr_data", {24'd0, arr_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Identity A against all-ones B.
        for (int i = 0; i < 8; i++) begin
            ma[i] = 8'(1 << i);
            mb[i] = 8'hFF;
        end
        base = ro_cycles;
        load_ops();
        drain(0);
        check("ident_readout_len", ro_cycles - base, 9);

        // Zero A against random B.
        rand_ops();
        for (int i = 0; i < 8; i++) ma[i] = 8'h00;
        base = ro_cycles;
        load_ops();
        drain(0);
        check("zero_readout_len", ro_cycles - base, 9);

        // All-ones A against identity B: inspect the skewed stream.
        for (int i = 0; i < 8; i++) begin
            ma[i] = 8'hFF;
            mb[i] = 8'(1 << i);
        end
        base = ro_cycles;
        load_ops();
        guard = 0;
        while (arr_data === 8'h00 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("feed_first_phase", {31'd0, m_phase}, 32'd0);
        stream[0] = arr_data;
        for (int i = 1; i < 30; i++) begin
            @(negedge clk);
            stream[i] = arr_data;
        end
        check("step0_a", {24'd0, stream[0]}, 32'h01);
        check("step0_b", {24'd0, stream[1]}, 32'h01);
        check("step1_a", {24'd0, stream[2]}, 32'h03);
        check("step1_b", {24'd0, stream[3]}, 32'h00);
        check("step14_a", {24'd0, stream[28]}, 32'h80);
        check("step14_b", {24'd0, stream[29]}, 32'h80);
        off = 29;
        while (arr_readout !== 1'b1 && off < 200) begin
            @(negedge clk);
            off++;
        end
        check("readout_offset", off, 46);
        drain(0);
        check("ones_readout_len", ro_cycles - base, 9);

        // Random operands with host backpressure.
        rand_ops();
        load_ops();
        drain(5);

        // Reset pulse in the middle of FEED.
        rand_ops();
        load_ops();
        repeat (12) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_arr_data", {24'd0, arr_data}, 32'd0);
        check("abort_readout", {31'd0, arr_readout}, 32'd0);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rand_ops();
        load_ops();
        drain(0);

        // Host keeps in_valid high while the feeder is busy.
        rand_ops();
        load_ops();
        in_valid = 1'b1;
        hits = 0;
        guard = 0;
        while (out_valid !== 1'b1 && guard < 200) begin
            in_data = 8'($urandom);
            @(negedge clk);
            if (in_ready === 1'b1) hits++;
            guard++;
        end
        repeat (3) begin
            @(negedge clk);
            if (in_ready === 1'b1) hits++;
        end
        check("busy_ignores_input", hits, 0);
        in_valid = 1'b0;
        drain(0);

        // Follow-up run after the ignored traffic.
        rand_ops();
        load_ops();
        drain(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
